// File: rtl/apb_mem_completer_if.sv
// rtl/apb_mem_completer_if.sv - APB4 signal bundle between requester and memory completer
interface apb_mem_completer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic [2:0]            pprot;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_completer.sv
// rtl/apb_mem_completer.sv - APB4 word-addressed register memory with wait states, strobes and PSLVERR
module apb_mem_completer #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned           DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 1
) (
    input logic                pclk,
    input logic                preset,
    apb_mem_completer_if.slave bus
);
    localparam int unsigned LSB   = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   LIMIT      = {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(DEPTH * STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    // The setup phase is recognised while IDLE; the edge closing it captures
    // the address/control and lands in ACCESS with the wait count loaded.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic                 capture;
    logic                 write_q;
    logic                 err_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic                  dec_err;
    logic [IDX_W-1:0]      dec_idx;
    logic                  complete;
    logic                  unused_bits;

    assign offset  = bus.paddr - BASE_ADDR;
    assign dec_err = ({1'b0, bus.paddr} < {1'b0, BASE_ADDR})
                   | ({1'b0, bus.paddr} >= LIMIT)
                   | (|(bus.paddr & ALIGN_MASK));
    assign dec_idx = IDX_W'(offset >> LSB);
    assign unused_bits = ^{bus.pprot, offset};

    assign complete = (state_q == ACCESS) && (wait_q == 4'd0) && bus.psel;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_STATES);
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pready  = complete;
    assign bus.pslverr = complete && err_q;
    assign bus.prdata  = (complete && !write_q && !err_q) ? mem[idx_q] : '0;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (capture) begin
                write_q <= bus.pwrite;
                err_q   <= dec_err;
                idx_q   <= dec_idx;
            end
            if (complete && write_q && !err_q) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (bus.pstrb[b]) begin
                        mem[idx_q][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_completer.sv
// tb/tb_apb_mem_completer.sv - self-checking bench for apb_mem_completer at 0, 1 and 3 wait states
module tb_apb_mem_completer;
    logic        pclk = 1'b0;
    logic        preset;
    logic        psel_r, penable_r, pwrite_r;
    logic [31:0] paddr_r, pwdata_r;
    logic [3:0]  pstrb_r;
    logic [2:0]  pprot_r;
    int          dut_sel;

    logic        rd_pready, rd_pslverr;
    logic [31:0] rd_prdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [4][16];

    always #5 pclk = ~pclk;

    apb_mem_completer_if bus0 ();
    apb_mem_completer_if bus1 ();
    apb_mem_completer_if bus3 ();

    assign bus0.psel = psel_r && (dut_sel == 0);
    assign bus1.psel = psel_r && (dut_sel == 1);
    assign bus3.psel = psel_r && (dut_sel == 3);
    assign bus0.penable = penable_r;
    assign bus1.penable = penable_r;
    assign bus3.penable = penable_r;
    assign bus0.pwrite = pwrite_r;
    assign bus1.pwrite = pwrite_r;
    assign bus3.pwrite = pwrite_r;
    assign bus0.paddr = paddr_r;
    assign bus1.paddr = paddr_r;
    assign bus3.paddr = paddr_r;
    assign bus0.pwdata = pwdata_r;
    assign bus1.pwdata = pwdata_r;
    assign bus3.pwdata = pwdata_r;
    assign bus0.pstrb = pstrb_r;
    assign bus1.pstrb = pstrb_r;
    assign bus3.pstrb = pstrb_r;
    assign bus0.pprot = pprot_r;
    assign bus1.pprot = pprot_r;
    assign bus3.pprot = pprot_r;

    apb_mem_completer #(.WAIT_STATES(0)) u_dut0 (.pclk(pclk), .preset(preset), .bus(bus0.slave));
    apb_mem_completer #(.WAIT_STATES(1)) u_dut1 (.pclk(pclk), .preset(preset), .bus(bus1.slave));
    apb_mem_completer #(.WAIT_STATES(3)) u_dut3 (.pclk(pclk), .preset(preset), .bus(bus3.slave));

    always_comb begin
        rd_pready  = bus1.pready;
        rd_pslverr = bus1.pslverr;
        rd_prdata  = bus1.prdata;
        case (dut_sel)
            0: begin rd_pready = bus0.pready; rd_pslverr = bus0.pslverr; rd_prdata = bus0.prdata; end
            3: begin rd_pready = bus3.pready; rd_pslverr = bus3.pslverr; rd_prdata = bus3.prdata; end
            default: ;
        endcase
    end

    // Reference model: 16 words at byte addresses 0..0x3C, word aligned.
    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'h40) && (a[1:0] == 2'b00);
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 4; d++)
            for (int w = 0; w < 16; w++)
                ref_mem[d][w] = 32'h0;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a, input logic [31:0] v,
                                        input logic [3:0] st);
        logic [31:0] old;
        if (!addr_ok(a)) return;
        old = ref_mem[d][a / 4];
        for (int b = 0; b < 4; b++)
            if (st[b]) old[b*8 +: 8] = v[b*8 +: 8];
        ref_mem[d][a / 4] = old;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        return addr_ok(a) ? ref_mem[d][a / 4] : 32'h0;
    endfunction

    task automatic go_idle();
        @(posedge pclk); #1;
        psel_r = 1'b0; penable_r = 1'b0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int lat, output int glitch);
        glitch = 0; lat = -1; rd = '0; err = 1'b0;
        @(posedge pclk); #1;
        dut_sel = d; psel_r = 1'b1; penable_r = 1'b0; pwrite_r = wr;
        paddr_r = a; pwdata_r = wd; pstrb_r = st; pprot_r = 3'($urandom);
        @(negedge pclk);
        if (rd_pready || rd_pslverr || rd_prdata != 32'h0) glitch++;
        @(posedge pclk); #1;
        penable_r = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            if (rd_pready) begin
                lat = c; rd = rd_prdata; err = rd_pslverr;
                break;
            end
            if (rd_pslverr || rd_prdata != 32'h0) glitch++;
            @(posedge pclk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        preset = 1'b1; psel_r = 1'b0; penable_r = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge pclk);
        n_checks++; if ({bus0.pready, bus1.pready, bus3.pready} !== 3'b000) $display("FAIL reset_pready got=%b exp=000", {bus0.pready, bus1.pready, bus3.pready}); else n_pass++;
        n_checks++; if ({bus0.pslverr, bus1.pslverr, bus3.pslverr} !== 3'b000) $display("FAIL reset_pslverr got=%b exp=000", {bus0.pslverr, bus1.pslverr, bus3.pslverr}); else n_pass++;
        n_checks++; if ((bus0.prdata | bus1.prdata | bus3.prdata) !== 32'h0) $display("FAIL reset_prdata got=%h exp=0", bus0.prdata | bus1.prdata | bus3.prdata); else n_pass++;
    endtask

    task automatic test_read_all();
        logic [31:0] rd; logic err; int lat, gl;
        for (int i = 0; i < 16; i++) begin
            xfer(1, 1'b0, 32'(i * 4), 32'h0, 4'($urandom), rd, err, lat, gl);
            n_checks++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL read_all[%0d] prdata=%h pslverr=%b exp=0/0", i, rd, err); else n_pass++;
            n_checks++; if (lat !== 2 || gl !== 0) $display("FAIL read_all_lat[%0d] access_cycles=%0d glitches=%0d exp=2/0", i, lat, gl); else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic err; int lat, gl;
        xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, rd, err, lat, gl);
        model_write(1, 32'h08, 32'hDEADBEEF, 4'b1111);
        xfer(1, 1'b1, 32'h08, 32'h000000AA, 4'b0001, rd, err, lat, gl);
        model_write(1, 32'h08, 32'h000000AA, 4'b0001);
        n_checks++; if (err !== 1'b0 || lat !== 2) $display("FAIL strobe_write pslverr=%b lat=%0d exp=0/2", err, lat); else n_pass++;
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== 32'hDEADBEAA) $display("FAIL strobe_read got=%h exp=deadbeaa", rd); else n_pass++;
        go_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, v; logic err; int lat, gl;
        v = $urandom;
        xfer(3, 1'b1, 32'h04, v, 4'hF, rd, err, lat, gl);
        model_write(3, 32'h04, v, 4'hF);
        n_checks++; if (lat !== 4 || gl !== 0) $display("FAIL ws3_write access_cycles=%0d glitches=%0d exp=4/0", lat, gl); else n_pass++;
        xfer(3, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== model_read(3, 32'h04) || lat !== 4) $display("FAIL ws3_read got=%h lat=%0d exp=%h/4", rd, lat, model_read(3, 32'h04)); else n_pass++;
        go_idle();
        v = $urandom;
        xfer(0, 1'b1, 32'h04, v, 4'hF, rd, err, lat, gl);
        model_write(0, 32'h04, v, 4'hF);
        n_checks++; if (lat !== 1 || gl !== 0) $display("FAIL ws0_write access_cycles=%0d glitches=%0d exp=1/0", lat, gl); else n_pass++;
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== v || lat !== 1) $display("FAIL ws0_read got=%h lat=%0d exp=%h/1", rd, lat, v); else n_pass++;
        go_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat, gl;
        xfer(1, 1'b1, 32'h04, 32'hCAFE0001, 4'hF, rd, err, lat, gl);
        model_write(1, 32'h04, 32'hCAFE0001, 4'hF);
        xfer(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, err, lat, gl);
        n_checks++; if (err !== 1'b1 || lat !== 2) $display("FAIL err_range_write pslverr=%b lat=%0d exp=1/2", err, lat); else n_pass++;
        xfer(1, 1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, rd, err, lat, gl);
        n_checks++; if (err !== 1'b1 || lat !== 2) $display("FAIL err_align_write pslverr=%b lat=%0d exp=1/2", err, lat); else n_pass++;
        xfer(1, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, rd, err, lat, gl);
        model_write(1, 32'h3C, 32'h0BADF00D, 4'hF);
        n_checks++; if (err !== 1'b0) $display("FAIL top_word_write pslverr=%b exp=0", err); else n_pass++;
        xfer(1, 1'b1, 32'h04, 32'h12121212, 4'h0, rd, err, lat, gl);
        n_checks++; if (err !== 1'b0) $display("FAIL strb0_write pslverr=%b exp=0", err); else n_pass++;
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== 32'h0 || err !== 1'b1) $display("FAIL err_read prdata=%h pslverr=%b exp=0/1", rd, err); else n_pass++;
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== 32'hCAFE0001) $display("FAIL err_unchanged got=%h exp=cafe0001", rd); else n_pass++;
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== model_read(1, 32'h3C) || err !== 1'b0) $display("FAIL top_word_read got=%h exp=%h", rd, model_read(1, 32'h3C)); else n_pass++;
        go_idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat, gl, seen;
        xfer(3, 1'b1, 32'h0C, 32'h55AA55AA, 4'hF, rd, err, lat, gl);
        model_write(3, 32'h0C, 32'h55AA55AA, 4'hF);
        go_idle();
        seen = 0;
        @(posedge pclk); #1;
        dut_sel = 3; psel_r = 1'b1; penable_r = 1'b0; pwrite_r = 1'b1;
        paddr_r = 32'h0C; pwdata_r = 32'h12345678; pstrb_r = 4'hF;
        @(posedge pclk); #1 penable_r = 1'b1;
        @(negedge pclk); seen += int'(rd_pready);
        @(posedge pclk); #1 psel_r = 1'b0; penable_r = 1'b0;
        repeat (5) begin @(negedge pclk); seen += int'(rd_pready); end
        n_checks++; if (seen !== 0) $display("FAIL abort_pready got=%0d exp=0", seen); else n_pass++;
        xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== 32'h55AA55AA) $display("FAIL abort_nowrite got=%h exp=55aa55aa", rd); else n_pass++;
        go_idle();
        @(posedge pclk); #1;
        psel_r = 1'b1; penable_r = 1'b0; pwrite_r = 1'b1;
        paddr_r = 32'h0C; pwdata_r = 32'h12345678; pstrb_r = 4'hF;
        @(posedge pclk); #1 penable_r = 1'b1;
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0; psel_r = 1'b0; penable_r = 1'b0;
        model_clear();
        xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== 32'h0 || lat !== 4) $display("FAIL reset_midwrite got=%h lat=%0d exp=0/4", rd, lat); else n_pass++;
        go_idle();
    endtask

    task automatic test_penable_only();
        logic [31:0] rd; logic err; int lat, gl, seen;
        seen = 0;
        @(posedge pclk); #1;
        dut_sel = 1; psel_r = 1'b1; penable_r = 1'b1; pwrite_r = 1'b1;
        paddr_r = 32'h00; pwdata_r = 32'hFFFFFFFF; pstrb_r = 4'hF;
        repeat (5) begin @(negedge pclk); seen += int'(rd_pready); end
        n_checks++; if (seen !== 0) $display("FAIL penable_no_setup pready_cycles=%0d exp=0", seen); else n_pass++;
        go_idle();
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, lat, gl);
        n_checks++; if (rd !== model_read(1, 32'h00)) $display("FAIL penable_no_write got=%h exp=%h", rd, model_read(1, 32'h00)); else n_pass++;
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, v; logic err; int lat, gl;
        foreach (ref_mem[d]) begin
            if (d == 2) continue;
            v = $urandom;
            xfer(d, 1'b1, 32'h00, v, 4'hF, rd, err, lat, gl);
            model_write(d, 32'h00, v, 4'hF);
            xfer(d, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, lat, gl);
            n_checks++; if (rd !== v || lat !== d + 1) $display("FAIL b2b[ws%0d] got=%h lat=%0d exp=%h/%0d", d, rd, lat, v, d + 1); else n_pass++;
            go_idle();
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, v, exp; logic err; logic [3:0] st; int lat, gl, d, prev_d;
        bit wr;
        prev_d = 1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2)) 0: d = 0; 1: d = 1; default: d = 3; endcase
            if (d != prev_d || $urandom_range(0, 3) == 0) go_idle();
            prev_d = d;
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 'h4F)) : 32'($urandom_range(0, 15) * 4);
            wr = 1'($urandom);
            v  = $urandom;
            st = 4'($urandom);
            exp = model_read(d, a);
            xfer(d, wr, a, v, st, rd, err, lat, gl);
            if (wr) model_write(d, a, v, st);
            else begin
                n_checks++; if (rd !== exp) $display("FAIL rand_read[%0d] ws%0d addr=%h got=%h exp=%h", i, d, a, rd, exp); else n_pass++;
            end
            n_checks++; if (err !== !addr_ok(a) || lat !== d + 1 || gl !== 0) $display("FAIL rand_resp[%0d] ws%0d addr=%h pslverr=%b lat=%0d gl=%0d exp=%b/%0d/0", i, d, a, err, lat, gl, !addr_ok(a), d + 1); else n_pass++;
        end
        go_idle();
        for (int w = 0; w < 16; w++) begin
            xfer(3, 1'b0, 32'(w * 4), 32'h0, 4'h0, rd, err, lat, gl);
            n_checks++; if (rd !== ref_mem[3][w]) $display("FAIL rand_final[%0d] got=%h exp=%h", w, rd, ref_mem[3][w]); else n_pass++;
        end
        go_idle();
    endtask

    initial begin
        preset = 1'b1; psel_r = 1'b0; penable_r = 1'b0; pwrite_r = 1'b0;
        paddr_r = '0; pwdata_r = '0; pstrb_r = '0; pprot_r = '0; dut_sel = 1;
        model_clear();
        test_reset();
        do_reset();
        test_reset();
        test_read_all();
        test_strobe();
        test_wait_states();
        test_errors();
        test_abort();
        test_penable_only();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
